binary_to_bcd_converter: RTL and testbench

- Sequential double-dabble converter: takes an unsigned binary value and produces a DIGITS_COUNT-digit packed BCD result, one shift-and-adjust step per clock.
- Feeds BCD-domain logic (score accumulation through the BCD adder, score display) from binary-domain sources such as counters and the pipe generator.
- Uses valid/ready handshakes on both sides.
- Results of DIGITS_COUNT*4 bits wide are directly compatible with the BCD adder operands.

---
 rtl/binary_to_bcd_converter.sv | 154 +++++++++++++++
 tb/tb_binary_to_bcd_converter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift-and-adjust step per clock, valid/ready handshake on input and
// output. A sticky flag records any carry lost off the top digit, which is
// exactly the condition bin >= 10**DIGITS_COUNT.
module binary_to_bcd_converter #(
    parameter int DIGITS_COUNT = 2,
    parameter int BIN_WIDTH    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGITS_COUNT*4-1:0] bcd,
    output logic                      overflow
);

    localparam int BCD_W = DIGITS_COUNT * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more, so the following doubling
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS_COUNT; i++) begin
            if (s[i*4+:4] >= 4'd5) begin
                r[i*4+:4] = s[i*4+:4] + 4'd3;
            end else begin
                r[i*4+:4] = s[i*4+:4];
            end
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [BIN_WIDTH-1:0] shift_r;
    logic [BCD_W-1:0]    scratch_r;
    logic                ovf_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [BCD_W-1:0]    bcd_r;
    logic                overflow_r;
    logic                in_ready_r;
    logic                out_valid_r;

    logic [BCD_W-1:0]    adjusted_s;
    logic [BCD_W-1:0]    scratch_next_s;
    logic [BIN_WIDTH-1:0] shift_next_s;
    logic                carry_s;
    logic                ovf_next_s;
    logic                last_step_s;

    // One double-dabble step: adjust digits, then shift {scratch, shift} left.
    always_comb begin
        adjusted_s = dabble_adjust(scratch_r);
        {carry_s, scratch_next_s, shift_next_s} = {adjusted_s, shift_r, 1'b0};
        ovf_next_s  = ovf_r | carry_s;
        last_step_s = (cnt_r == LAST_STEP);
    end

    // Next-state logic for IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Datapath: latch input, run the steps, publish result on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= '0;
            scratch_r  <= '0;
            ovf_r      <= 1'b0;
            cnt_r      <= '0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shift_r   <= bin;
                        scratch_r <= '0;
                        ovf_r     <= 1'b0;
                        cnt_r     <= '0;
                    end
                end
                SHIFT: begin
                    shift_r   <= shift_next_s;
                    scratch_r <= scratch_next_s;
                    ovf_r     <= ovf_next_s;
                    // Counter stops at BIN_WIDTH, which always fits in CNT_W bits.
                    cnt_r     <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        bcd_r      <= scratch_next_s;
                        overflow_r <= ovf_next_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign bcd       = bcd_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter: a per-cycle compare
// against an arithmetic reference model, directed scenarios with literal
// expectations, random traffic, and a second instance with wider parameters.
module tb_binary_to_bcd_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, overflow;
    logic [6:0] bin;
    logic [7:0] bcd;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, overflow1;
    logic [9:0]  bin1;
    logic [11:0] bcd1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    binary_to_bcd_converter #(.DIGITS_COUNT(2), .BIN_WIDTH(7)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .bcd(bcd), .overflow(overflow)
    );

    binary_to_bcd_converter #(.DIGITS_COUNT(3), .BIN_WIDTH(10)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .bcd(bcd1), .overflow(overflow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of v, packed 4 bits per digit, d digits.
    function automatic logic [15:0] to_bcd(input int v, input int d);
        logic [15:0] r;
        int x;
        r = 16'h0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[i*4+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model for u0: a busy timer of BIN_WIDTH edges, then a
    // result held until out_ready.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    int          m_val  = 0;
    logic [15:0] m_bcd  = 16'h0;
    bit          m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 1'b0; m_bcd = 16'h0; m_ovf = 1'b0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_done = 1'b1;
                m_bcd  = to_bcd(m_val % 100, 2);
                m_ovf  = (m_val >= 100);
            end
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (in_valid) begin
            m_val  = int'(bin);
            m_busy = 7;
        end
    end

    // Per-cycle compare of u0 against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", {31'h0, in_ready}, {31'h0, (m_busy == 0 && !m_done)});
            chk("cyc_out_valid", {31'h0, out_valid}, {31'h0, m_done});
            chk("cyc_bcd", {24'h0, bcd}, {16'h0, m_bcd});
            chk("cyc_overflow", {31'h0, overflow}, {31'h0, m_ovf});
        end
    end

    task automatic send(input int v);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", 32'h0, 32'h1);
        in_valid = 1'b1;
        bin = 7'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert(input int v, input logic [7:0] exp_bcd, input bit exp_ovf);
        int lat;
        send(v);
        wait_result(lat);
        chk("latency", 32'(lat), 32'd7);
        chk("bcd_lit", {24'h0, bcd}, {24'h0, exp_bcd});
        chk("ovf_lit", {31'h0, overflow}, {31'h0, exp_ovf});
        @(negedge clk);
        chk("valid_one_cycle", {31'h0, out_valid}, 32'h0);
    endtask

    task automatic convert1(input int v, input logic [11:0] exp_bcd, input bit exp_ovf);
        int lat;
        chk("w_in_ready", {31'h0, in_ready1}, 32'h1);
        in_valid1 = 1'b1;
        bin1 = 10'(v);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("w_latency", 32'(lat), 32'd10);
        chk("w_bcd", {20'h0, bcd1}, {20'h0, exp_bcd});
        chk("w_ovf", {31'h0, overflow1}, {31'h0, exp_ovf});
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int dec;
        rst = 1'b1; in_valid = 1'b0; bin = 7'd0; out_ready = 1'b1;
        in_valid1 = 1'b0; bin1 = 10'd0; out_ready1 = 1'b1;

        // Pin the model's arithmetic with hand values.
        chk("pin_42", {16'h0, to_bcd(42, 2)}, 32'h42);
        chk("pin_27", {16'h0, to_bcd(127 % 100, 2)}, 32'h27);
        chk("pin_999", {16'h0, to_bcd(999, 3)}, 32'h999);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_bcd", {24'h0, bcd}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk_en = 1'b1;

        // Basic and overflow values.
        convert(0, 8'h00, 1'b0);
        convert(42, 8'h42, 1'b0);
        convert(99, 8'h99, 1'b0);
        convert(127, 8'h27, 1'b1);
        convert(100, 8'h00, 1'b1);

        // Backpressure with an ignored input in the hold window.
        out_ready = 1'b0;
        send(57);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            bin = 7'd3;
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_bcd", {24'h0, bcd}, 32'h57);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
        chk("bp_release_valid", {31'h0, out_valid}, 32'h0);

        // Reset in the middle of a conversion.
        send(88);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mr_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mr_bcd", {24'h0, bcd}, 32'h0);
        chk("mr_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mr_no_pulse", {31'h0, out_valid}, 32'h0);
        end
        convert(12, 8'h12, 1'b0);

        // Exhaustive loopback over every 7-bit value.
        for (int v = 0; v < 128; v++) begin
            send(v);
            wait_result(lat);
            dec = int'(bcd[3:0]) + 10 * int'(bcd[7:4]) + 100 * int'(overflow);
            chk("loopback", 32'(dec), 32'(v));
            @(negedge clk);
        end

        // Random traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            bin       = 7'($urandom_range(0, 127));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(negedge clk);

        // Wider instance: 3 digits, 10-bit input.
        convert1(999, 12'h999, 1'b0);
        convert1(1023, 12'h023, 1'b1);
        convert1(305, 12'h305, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
